rv32_imm_gen_unit: RTL and testbench

- RV32I immediate generator for the decode stage; sits beside the instruction decoder.
- Takes one 32-bit instruction word, classifies its immediate format from the major opcode and assembles the 32-bit immediate.
- Result is registered: one-cycle latency, with a valid flag and a format code for downstream ALU/branch/CSR logic.

---
 rtl/rv32_imm_gen_unit.sv | 89 ++++++++
 tb/tb_rv32_imm_gen_unit.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rv32_imm_gen_unit.sv
// RV32I immediate generator for the decode stage.
// The major opcode selects the immediate format. The sign-extended immediate
// and its format code are registered, so the result appears one cycle after
// the instruction is sampled.
module rv32_imm_gen_unit #(
    parameter int XPR_LEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [XPR_LEN-1:0] rv_instr,
    input  logic               instr_valid,
    output logic [XPR_LEN-1:0] rv_imm,
    output logic [2:0]         imm_fmt,
    output logic               imm_valid
);

    // Format codes as seen by downstream ALU/branch/CSR logic; 6-7 unused.
    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    imm_fmt_e           fmt_next;
    logic [XPR_LEN-1:0] imm_next;

    // Classify the immediate format from the major opcode alone; funct3/funct7
    // legality belongs to the decoder.
    always_comb begin
        // NOTE: default assignment first so every path drives fmt_next and no latch is inferred.
        fmt_next = FMT_NONE;
        case (rv_instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt_next = FMT_I;
            OPC_STORE:                                  fmt_next = FMT_S;
            OPC_BRANCH:                                 fmt_next = FMT_B;
            OPC_LUI, OPC_AUIPC:                         fmt_next = FMT_U;
            OPC_JAL:                                    fmt_next = FMT_J;
            default:                                    fmt_next = FMT_NONE;
        endcase
    end

    // Assemble the immediate; bit 31 is the sign source for every format.
    // Shift-immediates keep funct7 in imm[11:5] and SYSTEM yields the CSR
    // address, both as plain I-type.
    always_comb begin
        imm_next = '0;
        case (fmt_next)
            FMT_I: imm_next = {{21{rv_instr[31]}}, rv_instr[30:20]};
            FMT_S: imm_next = {{21{rv_instr[31]}}, rv_instr[30:25], rv_instr[11:7]};
            FMT_B: imm_next = {{20{rv_instr[31]}}, rv_instr[7], rv_instr[30:25],
                               rv_instr[11:8], 1'b0};
            FMT_U: imm_next = {rv_instr[31:12], 12'b0};
            FMT_J: imm_next = {{12{rv_instr[31]}}, rv_instr[19:12], rv_instr[20],
                               rv_instr[30:21], 1'b0};
            default: imm_next = '0;
        endcase
    end

    // Output registers: synchronous reset; load on valid, otherwise hold
    // the last result and drop the valid flag.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
        if (!rst_n) begin
            rv_imm    <= '0;
            imm_fmt   <= FMT_NONE;
            imm_valid <= 1'b0;
        end else begin
            imm_valid <= instr_valid;
            if (instr_valid) begin
                rv_imm  <= imm_next;
                imm_fmt <= fmt_next;
            end
        end
    end

endmodule

// File: tb/tb_rv32_imm_gen_unit.sv
// Directed testbench for rv32_imm_gen_unit: hand-encoded RV32I instructions
// with hand-computed immediates, checked one cycle after each is sampled.
module tb_rv32_imm_gen_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] rv_instr;
    logic        instr_valid;
    logic [31:0] rv_imm;
    logic [2:0]  imm_fmt;
    logic        imm_valid;

    int checks = 0;
    int errors = 0;

    rv32_imm_gen_unit #(.XPR_LEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rv_instr    (rv_instr),
        .instr_valid (instr_valid),
        .rv_imm      (rv_imm),
        .imm_fmt     (imm_fmt),
        .imm_valid   (imm_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one instruction, let one rising edge sample it, settle 1 time unit.
    task automatic cycle(input logic [31:0] instr, input logic valid);
        rv_instr    = instr;
        instr_valid = valid;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] imm,
                              input logic [2:0] fmt, input logic vld);
        check({tag, ".imm"},   rv_imm,           imm);
        check({tag, ".fmt"},   {29'b0, imm_fmt}, {29'b0, fmt});
        check({tag, ".valid"}, {31'b0, imm_valid}, {31'b0, vld});
    endtask

    initial begin
        rst_n       = 1'b0;
        rv_instr    = 32'h0;
        instr_valid = 1'b0;

        // Reset overrides a valid instruction for two edges.
        cycle(32'hFFF00093, 1'b1);
        cycle(32'hFFF00093, 1'b1);
        expect_out("reset", 32'h0, 3'd0, 1'b0);

        rst_n = 1'b1;
        cycle(32'hFFF00093, 1'b1);                       // addi x1,x0,-1
        expect_out("addi", 32'hFFFFFFFF, 3'd1, 1'b1);
        cycle(32'hFE20AE23, 1'b1);                       // sw x2,-4(x1)
        expect_out("sw", 32'hFFFFFFFC, 3'd2, 1'b1);
        cycle(32'h00000463, 1'b1);                       // beq x0,x0,+8
        expect_out("beq_p8", 32'h00000008, 3'd3, 1'b1);
        cycle(32'hFE000EE3, 1'b1);                       // beq x0,x0,-4 (bit7 -> imm[11])
        expect_out("beq_m4", 32'hFFFFFFFC, 3'd3, 1'b1);
        cycle(32'hFFDFF06F, 1'b1);                       // jal x0,-4
        expect_out("jal_m4", 32'hFFFFFFFC, 3'd5, 1'b1);
        cycle(32'h0010006F, 1'b1);                       // jal x0,+2048 (bit20 -> imm[11])
        expect_out("jal_p2k", 32'h00000800, 3'd5, 1'b1);
        cycle(32'h123452B7, 1'b1);                       // lui x5,0x12345
        expect_out("lui", 32'h12345000, 3'd4, 1'b1);
        cycle(32'h80000297, 1'b1);                       // auipc x5,0x80000
        expect_out("auipc", 32'h80000000, 3'd4, 1'b1);
        cycle(32'h4030D093, 1'b1);                       // srai x1,x1,3
        expect_out("srai", 32'h00000403, 3'd1, 1'b1);
        cycle(32'hC0002073, 1'b1);                       // csrrs x0,cycle,x0
        expect_out("csr", 32'hFFFFFC00, 3'd1, 1'b1);
        cycle(32'h7FF08067, 1'b1);                       // jalr x0,2047(x1)
        expect_out("jalr", 32'h000007FF, 3'd1, 1'b1);
        cycle(32'h80012083, 1'b1);                       // lw x1,-2048(x2)
        expect_out("lw", 32'hFFFFF800, 3'd1, 1'b1);
        cycle(32'h0FF0000F, 1'b1);                       // fence
        expect_out("fence", 32'h0, 3'd0, 1'b1);

        // NONE result, then hold while invalid.
        cycle(32'h002081B3, 1'b1);                       // add x3,x1,x2
        expect_out("add", 32'h0, 3'd0, 1'b1);
        cycle(32'hFFF00093, 1'b0);
        expect_out("hold_none", 32'h0, 3'd0, 1'b0);

        // Hold a non-zero result across invalid cycles.
        cycle(32'hFFF00093, 1'b1);
        expect_out("addi2", 32'hFFFFFFFF, 3'd1, 1'b1);
        cycle(32'h123452B7, 1'b0);
        expect_out("hold_i_1", 32'hFFFFFFFF, 3'd1, 1'b0);
        cycle(32'h00000463, 1'b0);
        expect_out("hold_i_2", 32'hFFFFFFFF, 3'd1, 1'b0);

        // Mid-stream reset for one edge, then resume with 1-cycle latency.
        cycle(32'h123452B7, 1'b1);
        expect_out("pre_rst", 32'h12345000, 3'd4, 1'b1);
        rst_n = 1'b0;
        cycle(32'h80000297, 1'b1);
        expect_out("mid_rst", 32'h0, 3'd0, 1'b0);
        rst_n = 1'b1;
        cycle(32'h80000297, 1'b1);
        expect_out("post_rst", 32'h80000000, 3'd4, 1'b1);
        cycle(32'hFE20AE23, 1'b1);
        expect_out("post_rst_sw", 32'hFFFFFFFC, 3'd2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
